spi_cfg_regbank: RTL and testbench
==================================

// Module: spi_cfg_regbank
// PURPOSE
//  Parametrised SPI configuration register bank; successor of the fixed 8x32-bit write-only config block.
//  Decodes the byte stream from spi_slave into write and read-back frames over NUM_REGS registers of DATA_W bits.
//  Adds register read-back, address range checking, an inter-byte timeout and abort on slave-select release.
//  Sits between spi_slave (byte valid/ready port) and the DDS/measurement parameter consumers.
// PARAMETERS
//  NUM_REGS     16          number of registers, 1..256
//  DATA_BYTES   4           bytes per register; DATA_W = 8*DATA_BYTES
//  RESET_VALUE  0           reset value of every register (DATA_W bits)
//  TIMEOUT_CYC  50000       clk cycles allowed between bytes inside a frame; 0 disables timeout
//  WR_SYNC      8'h5A       write-frame sync byte
//  RD_SYNC      8'hA5       read-frame sync byte
// PORTS
//  clk          in   1                  system clock
//  rstn         in   1                  asynchronous active-low reset
//  spi_ss_n     in   1                  slave select seen by spi_slave (synchronised in here, 2 flops)
//  s_valid      in   1                  spi_slave has a received byte
//  s_ready      out  1                  this block accepts the byte; transfer when s_valid & s_ready
//  s_rx_data    in   8                  received byte
//  s_tx_data    out  8                  byte spi_slave shifts out on the next transfer
//  regs         out  NUM_REGS*DATA_W    flat register contents, reg i at [i*DATA_W +: DATA_W]
//  wr_en        out  1                  one-cycle pulse when a register is written
//  wr_addr      out  8                  address of the write, valid with wr_en
//  err_addr     out  1                  sticky: frame addressed reg >= NUM_REGS; cleared by next valid frame
//  err_timeout  out  1                  one-cycle pulse when a frame is aborted by timeout or ss_n release
// BEHAVIOUR
//  Reset (async, rstn=0): all regs=RESET_VALUE, s_ready=0, s_tx_data=0, wr_en=0, wr_addr=0,
//   err_addr=0, err_timeout=0, state=IDLE, byte counter=0, timeout counter=0.
//  Frame format: SYNC, ADDR, then DATA_BYTES bytes, LSB byte first.
//  States: IDLE, ADDR, WDATA, WRITE, RDATA.
//  IDLE: s_ready=1, s_tx_data=0. Accepted WR_SYNC -> ADDR(write); RD_SYNC -> ADDR(read); other bytes dropped.
//  ADDR: accepted byte latched as address. Write -> WDATA. Read -> RDATA; same edge loads shadow
//   with regs[addr] (0 if addr >= NUM_REGS) and drives s_tx_data = shadow byte 0.
//  WDATA: byte k (k=0..DATA_BYTES-1) stored at data_buf[8k+:8]; after byte DATA_BYTES-1 -> WRITE.
//  WRITE (1 cycle, s_ready=0): addr < NUM_REGS -> regs[addr]<=data_buf, wr_en=1, wr_addr=addr,
//   err_addr<=0; else no write, wr_en=0, err_addr<=1. -> IDLE. regs update visible the cycle after WRITE.
//  RDATA: each accepted byte (content ignored) advances s_tx_data to the next shadow byte;
//   after DATA_BYTES transfers s_tx_data<=0, err_addr<=(addr>=NUM_REGS), -> IDLE.
//  Read latency: regs value is the one present at ADDR acceptance; a concurrent write is not seen.
//  s_tx_data changes only on the edge of an accepted byte, so spi_slave samples it stable.
//  Timeout: counter clears on every accepted byte and in IDLE; counts in ADDR/WDATA/RDATA;
//   reaching TIMEOUT_CYC -> IDLE, err_timeout pulse, no register write, s_tx_data<=0.
//  ss_n rising edge (synchronised) while not in IDLE -> same abort as timeout; in IDLE no effect.
//  Abort and a byte acceptance in the same cycle: abort wins, byte discarded.
//  Addresses wider than needed: compare full 8-bit address with NUM_REGS; never wrap modulo NUM_REGS.
//  wr_en never asserts in consecutive cycles (minimum frame is DATA_BYTES+2 bytes).
//  Reset asserted mid-frame: immediate return to reset values, partial frame lost.
// TESTING
//  Write 5A 03 78 56 34 12 -> wr_en one cycle, wr_addr=3, regs[3]=32'h12345678, others unchanged.
//  After above, read A5 03 00 00 00 00 -> s_tx_data bytes 78,56,34,12 on transfers 3..6; regs unchanged.
//  Write 5A 20 (NUM_REGS=16) + 4 bytes -> no wr_en, err_addr=1; next valid write clears err_addr.
//  Write 5A 01 AA BB then idle TIMEOUT_CYC cycles -> err_timeout pulse, regs[1] unchanged, next 5A frame OK.
//  Write 5A 02 11 then ss_n rises -> abort pulse, regs[2] unchanged; garbage bytes 00 FF in IDLE ignored.
//  DATA_BYTES=2, NUM_REGS=4, RESET_VALUE=16'hBEEF: after reset all regs=BEEF; 5A 00 34 12 -> regs[0]=16'h1234.

Source files
------------

// File: rtl/spi_cfg_regbank.sv
// SPI configuration register bank: decodes SYNC/ADDR/DATA byte frames from spi_slave
// into register writes and read-backs, with address checking, inter-byte timeout and ss_n abort.
module spi_cfg_regbank #(
  parameter int                    NUM_REGS    = 16,
  parameter int                    DATA_BYTES  = 4,
  parameter logic [8*DATA_BYTES-1:0] RESET_VALUE = '0,
  parameter int                    TIMEOUT_CYC = 50000,
  parameter logic [7:0]            WR_SYNC     = 8'h5A,
  parameter logic [7:0]            RD_SYNC     = 8'hA5
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               spi_ss_n,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [7:0]                         s_rx_data,
  output logic [7:0]                         s_tx_data,
  output logic [NUM_REGS*8*DATA_BYTES-1:0]   regs,
  output logic                               wr_en,
  output logic [7:0]                         wr_addr,
  output logic                               err_addr,
  output logic                               err_timeout
);

  localparam int DATA_W = 8 * DATA_BYTES;
  localparam int AW     = (NUM_REGS > 1)    ? $clog2(NUM_REGS)      : 1;
  localparam int BW     = (DATA_BYTES > 1)  ? $clog2(DATA_BYTES)    : 1;
  localparam int TW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC+1) : 1;

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRITE, RDATA} state_e;

  state_e              state_q;
  logic                is_rd_q;
  logic [7:0]          addr_q;
  logic [BW-1:0]       bcnt_q;
  logic [DATA_W-1:0]   data_buf_q;
  logic [DATA_W-1:0]   shadow_q;
  logic [TW-1:0]       tmo_q;
  logic [2:0]          ss_sync_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic                s_ready_q;
  logic [7:0]          tx_q;
  logic                wr_en_q;
  logic [7:0]          wr_addr_q;
  logic                err_addr_q;
  logic                err_timeout_q;

  logic                accept;
  logic                ss_rise;
  logic                counting;
  logic                tmo_hit;
  logic                abort;
  logic                rx_addr_ok;
  logic                addr_ok;
  logic                last_byte;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   shadow_nx;

  always_comb begin
    accept     = s_valid & s_ready_q;
    // ss_sync_q[1] is the synchronised level, [2] its previous value
    ss_rise    = ss_sync_q[1] & ~ss_sync_q[2];
    counting   = (state_q == ADDR) || (state_q == WDATA) || (state_q == RDATA);
    tmo_hit    = (TIMEOUT_CYC != 0) && counting && (tmo_q == TW'(TIMEOUT_CYC));
    abort      = (state_q != IDLE) && (ss_rise || tmo_hit);
    rx_addr_ok = int'(s_rx_data) < NUM_REGS;
    addr_ok    = int'(addr_q) < NUM_REGS;
    last_byte  = (bcnt_q == BW'(DATA_BYTES - 1));
    rd_word    = '0;
    if (rx_addr_ok) rd_word = regs_q[s_rx_data[AW-1:0]];
    shadow_nx  = shadow_q >> 8;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      is_rd_q       <= 1'b0;
      addr_q        <= '0;
      bcnt_q        <= '0;
      data_buf_q    <= '0;
      shadow_q      <= '0;
      tmo_q         <= '0;
      ss_sync_q     <= '1;
      s_ready_q     <= 1'b0;
      tx_q          <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      err_addr_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUE;
    end else begin
      ss_sync_q     <= {ss_sync_q[1:0], spi_ss_n};
      wr_en_q       <= 1'b0;
      err_timeout_q <= 1'b0;
      s_ready_q     <= 1'b1;
      if (counting) tmo_q <= tmo_q + TW'(1);
      else          tmo_q <= '0;

      // An abort takes priority over a byte accepted in the same cycle
      if (abort) begin
        state_q       <= IDLE;
        err_timeout_q <= 1'b1;
        tx_q          <= '0;
        bcnt_q        <= '0;
        tmo_q         <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              if (s_rx_data == WR_SYNC) begin
                is_rd_q <= 1'b0;
                state_q <= ADDR;
              end else if (s_rx_data == RD_SYNC) begin
                is_rd_q <= 1'b1;
                state_q <= ADDR;
              end
            end
          end
          ADDR: begin
            if (accept) begin
              tmo_q  <= '0;
              addr_q <= s_rx_data;
              bcnt_q <= '0;
              if (is_rd_q) begin
                shadow_q <= rd_word;
                tx_q     <= rd_word[7:0];
                state_q  <= RDATA;
              end else begin
                state_q  <= WDATA;
              end
            end
          end
          WDATA: begin
            if (accept) begin
              tmo_q <= '0;
              data_buf_q[8*int'(bcnt_q) +: 8] <= s_rx_data;
              if (last_byte) begin
                bcnt_q    <= '0;
                s_ready_q <= 1'b0;
                state_q   <= WRITE;
              end else begin
                bcnt_q <= bcnt_q + BW'(1);
              end
            end
          end
          WRITE: begin
            if (addr_ok) begin
              regs_q[addr_q[AW-1:0]] <= data_buf_q;
              wr_en_q    <= 1'b1;
              wr_addr_q  <= addr_q;
              err_addr_q <= 1'b0;
            end else begin
              err_addr_q <= 1'b1;
            end
            state_q <= IDLE;
          end
          RDATA: begin
            if (accept) begin
              tmo_q <= '0;
              if (last_byte) begin
                tx_q       <= '0;
                bcnt_q     <= '0;
                err_addr_q <= ~addr_ok;
                state_q    <= IDLE;
              end else begin
                shadow_q <= shadow_nx;
                tx_q     <= shadow_nx[7:0];
                bcnt_q   <= bcnt_q + BW'(1);
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    regs = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) regs[i*DATA_W +: DATA_W] = regs_q[i];
  end

  assign s_ready     = s_ready_q;
  assign s_tx_data   = tx_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign err_addr    = err_addr_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_spi_cfg_regbank.sv
// Directed bench for spi_cfg_regbank: a 16x32 instance with short timeout and a 4x16 instance
// with a non-zero reset value, driven byte-by-byte through the valid/ready port.
module tb_spi_cfg_regbank;

  localparam int TMO = 20;

  logic          clk = 1'b0;
  logic          rstn;
  logic          ss_n1, ss_n2;
  logic          s_valid1, s_valid2;
  logic          s_ready1, s_ready2;
  logic [7:0]    rx1, rx2, tx1, tx2;
  logic [511:0]  regs1;
  logic [63:0]   regs2;
  logic          wr_en1, wr_en2;
  logic [7:0]    wr_addr1, wr_addr2;
  logic          err_addr1, err_addr2;
  logic          err_to1, err_to2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_cfg_regbank #(.NUM_REGS(16), .DATA_BYTES(4), .RESET_VALUE(32'h0), .TIMEOUT_CYC(TMO),
                    .WR_SYNC(8'h5A), .RD_SYNC(8'hA5)) dut1 (
    .clk(clk), .rstn(rstn), .spi_ss_n(ss_n1), .s_valid(s_valid1), .s_ready(s_ready1),
    .s_rx_data(rx1), .s_tx_data(tx1), .regs(regs1), .wr_en(wr_en1), .wr_addr(wr_addr1),
    .err_addr(err_addr1), .err_timeout(err_to1));

  spi_cfg_regbank #(.NUM_REGS(4), .DATA_BYTES(2), .RESET_VALUE(16'hBEEF), .TIMEOUT_CYC(TMO),
                    .WR_SYNC(8'h5A), .RD_SYNC(8'hA5)) dut2 (
    .clk(clk), .rstn(rstn), .spi_ss_n(ss_n2), .s_valid(s_valid2), .s_ready(s_ready2),
    .s_rx_data(rx2), .s_tx_data(tx2), .regs(regs2), .wr_en(wr_en2), .wr_addr(wr_addr2),
    .err_addr(err_addr2), .err_timeout(err_to2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r1(input int i);
    return regs1[i*32 +: 32];
  endfunction

  function automatic logic [31:0] r2(input int i);
    return {16'h0, regs2[i*16 +: 16]};
  endfunction

  // One byte transfer; returns #1 after the accepting edge
  task automatic send(input bit d2, input logic [7:0] b);
    int unsigned n = 0;
    @(negedge clk);
    while (!(d2 ? s_ready2 : s_ready1) && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (n >= 8) check("ready_timeout", 32'(n), 32'd0);
    if (d2) begin s_valid2 = 1'b1; rx2 = b; end
    else    begin s_valid1 = 1'b1; rx1 = b; end
    @(posedge clk);
    #1;
    s_valid1 = 1'b0;
    s_valid2 = 1'b0;
  endtask

  task automatic wait_wr(input bit d2, input int unsigned lim, output bit seen);
    seen = 1'b0;
    for (int unsigned i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      if (d2 ? wr_en2 : wr_en1) seen = 1'b1;
    end
  endtask

  task automatic wait_to(input int unsigned lim, output int unsigned n);
    n = 0;
    while (n < lim) begin
      @(negedge clk);
      n++;
      if (err_to1) break;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit          seen;
    int unsigned n;

    rstn = 1'b1; ss_n1 = 1'b1; ss_n2 = 1'b1;
    s_valid1 = 1'b0; s_valid2 = 1'b0; rx1 = '0; rx2 = '0;
    #3 rstn = 1'b0;
    #17;
    check("rst_s_ready", 32'(s_ready1), 32'd0);
    check("rst_tx", 32'(tx1), 32'd0);
    check("rst_wr_en", 32'(wr_en1), 32'd0);
    check("rst_wr_addr", 32'(wr_addr1), 32'd0);
    check("rst_err_addr", 32'(err_addr1), 32'd0);
    check("rst_err_to", 32'(err_to1), 32'd0);
    for (int i = 0; i < 16; i++) check($sformatf("rst_reg%0d", i), r1(i), 32'h0);
    for (int i = 0; i < 4; i++) check($sformatf("d2_rst_reg%0d", i), r2(i), 32'h0000BEEF);
    @(negedge clk);
    rstn = 1'b1;
    ss_n1 = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_ready", 32'(s_ready1), 32'd1);

    // Basic write
    send(0, 8'h5A); send(0, 8'h03); send(0, 8'h78); send(0, 8'h56); send(0, 8'h34); send(0, 8'h12);
    check("write_state_ready", 32'(s_ready1), 32'd0);
    wait_wr(0, 5, seen);
    check("wr_en_pulse", 32'(seen), 32'd1);
    check("wr_addr", 32'(wr_addr1), 32'd3);
    check("reg3_written", r1(3), 32'h12345678);
    check("reg2_untouched", r1(2), 32'h0);
    check("reg4_untouched", r1(4), 32'h0);
    @(negedge clk);
    check("wr_en_one_cycle", 32'(wr_en1), 32'd0);

    // Read-back
    send(0, 8'hA5); send(0, 8'h03);
    check("rd_byte0", 32'(tx1), 32'h78);
    send(0, 8'h00); check("rd_byte1", 32'(tx1), 32'h56);
    send(0, 8'h00); check("rd_byte2", 32'(tx1), 32'h34);
    send(0, 8'h00); check("rd_byte3", 32'(tx1), 32'h12);
    send(0, 8'h00); check("rd_end_tx", 32'(tx1), 32'h00);
    check("rd_err_addr", 32'(err_addr1), 32'd0);
    check("rd_reg3_kept", r1(3), 32'h12345678);

    // Out-of-range write and read
    send(0, 8'h5A); send(0, 8'h20); send(0, 8'h01); send(0, 8'h02); send(0, 8'h03); send(0, 8'h04);
    wait_wr(0, 4, seen);
    check("oob_no_wr_en", 32'(seen), 32'd0);
    check("oob_err_addr", 32'(err_addr1), 32'd1);
    check("oob_reg0_kept", r1(0), 32'h0);
    send(0, 8'hA5); send(0, 8'h10);
    check("oob_rd_tx", 32'(tx1), 32'h00);
    send(0, 8'h00); send(0, 8'h00); send(0, 8'h00); send(0, 8'h00);
    check("oob_rd_err_addr", 32'(err_addr1), 32'd1);
    send(0, 8'h5A); send(0, 8'h05); send(0, 8'hEF); send(0, 8'hBE); send(0, 8'hAD); send(0, 8'hDE);
    wait_wr(0, 5, seen);
    check("valid_wr_en", 32'(seen), 32'd1);
    check("err_addr_cleared", 32'(err_addr1), 32'd0);
    check("reg5_written", r1(5), 32'hDEADBEEF);

    // Inter-byte timeout
    send(0, 8'h5A); send(0, 8'h01); send(0, 8'hAA); send(0, 8'hBB);
    wait_to(TMO + 10, n);
    check("timeout_pulse", 32'(err_to1), 32'd1);
    check("timeout_not_early", 32'(n >= TMO && n <= TMO + 2), 32'd1);
    @(negedge clk);
    check("timeout_one_cycle", 32'(err_to1), 32'd0);
    check("timeout_reg1_kept", r1(1), 32'h0);
    send(0, 8'h5A); send(0, 8'h01); send(0, 8'h01); send(0, 8'h02); send(0, 8'h03); send(0, 8'h04);
    wait_wr(0, 5, seen);
    check("after_to_reg1", r1(1), 32'h04030201);

    // Slave-select abort, then garbage in IDLE
    send(0, 8'h5A); send(0, 8'h02); send(0, 8'h11);
    ss_n1 = 1'b1;
    wait_to(8, n);
    check("ss_abort_pulse", 32'(err_to1), 32'd1);
    check("ss_abort_reg2_kept", r1(2), 32'h0);
    send(0, 8'h00); send(0, 8'hFF);
    check("garbage_tx", 32'(tx1), 32'h00);
    check("garbage_ready", 32'(s_ready1), 32'd1);
    ss_n1 = 1'b0;
    repeat (4) @(negedge clk);
    ss_n1 = 1'b1;
    wait_to(6, n);
    check("ss_idle_no_abort", 32'(err_to1), 32'd0);
    ss_n1 = 1'b0;
    repeat (4) @(negedge clk);
    send(0, 8'h5A); send(0, 8'h02); send(0, 8'h44); send(0, 8'h33); send(0, 8'h22); send(0, 8'h11);
    wait_wr(0, 5, seen);
    check("after_abort_wr_addr", 32'(wr_addr1), 32'd2);
    check("after_abort_reg2", r1(2), 32'h11223344);

    // Narrow instance with non-zero reset value
    send(1, 8'h5A); send(1, 8'h00); send(1, 8'h34); send(1, 8'h12);
    wait_wr(1, 5, seen);
    check("d2_wr_en", 32'(seen), 32'd1);
    check("d2_reg0", r2(0), 32'h00001234);
    check("d2_reg1_kept", r2(1), 32'h0000BEEF);
    send(1, 8'hA5); send(1, 8'h00);
    check("d2_rd_byte0", 32'(tx2), 32'h34);
    send(1, 8'h00); check("d2_rd_byte1", 32'(tx2), 32'h12);
    send(1, 8'h00); check("d2_rd_end", 32'(tx2), 32'h00);

    // Reset mid-frame
    send(0, 8'h5A); send(0, 8'h07); send(0, 8'h01);
    #2 rstn = 1'b0;
    #1;
    check("midrst_ready", 32'(s_ready1), 32'd0);
    check("midrst_reg5", r1(5), 32'h0);
    check("midrst_d2_reg0", r2(0), 32'h0000BEEF);
    @(negedge clk);
    rstn = 1'b1;
    send(0, 8'h5A); send(0, 8'h07); send(0, 8'hCC); send(0, 8'hDD); send(0, 8'hEE); send(0, 8'hFF);
    wait_wr(0, 5, seen);
    check("postrst_reg7", r1(7), 32'hFFEEDDCC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
